dcache_rd_port_arbiter: RTL and testbench
=========================================

// Module: dcache_rd_port_arbiter
// PURPOSE
//  Shares one write-through data-cache read port among NumPorts in-order requesters (load unit, PTW, debug).
//  Round-robin arbitration; the winner is held stable until the cache grants.
//  A small in-order tag FIFO routes each cache response back to the requester that issued it.
//  Sits between the load/PTW request ports and the WT dcache read port.
// PARAMETERS
//  NumPorts        3   number of requesters (>=2)
//  AddrWidth       32  request address width (XLEN)
//  DataWidth       32  read data width
//  MaxOutstanding  2   granted-but-unanswered reads tracked (>=1), equals the load buffer depth
// PORTS
//  clk_i            in   1                      clock
//  rst_i            in   1                      async reset, active-high
//  req_i            in   NumPorts               per-port read request; held until its gnt_o
//  addr_i           in   NumPorts*AddrWidth     per-port address (port p at [p*AddrWidth +: AddrWidth])
//  be_i             in   NumPorts*DataWidth/8   per-port byte enables
//  gnt_o            out  NumPorts               one-hot grant, same cycle as cache_gnt_i
//  rvalid_o         out  NumPorts               one-hot response valid
//  rdata_o          out  DataWidth              response data, broadcast to all ports
//  cache_req_o      out  1                      request to the cache port
//  cache_addr_o     out  AddrWidth              forwarded address
//  cache_be_o       out  DataWidth/8            forwarded byte enables
//  cache_gnt_i      in   1                      cache accepts the request
//  cache_rvalid_i   in   1                      cache response valid; responses return in request order
//  cache_rdata_i    in   DataWidth              cache response data
//  busy_o           out  1                      HOLD state or tag FIFO non-empty
//  err_o            out  1                      sticky protocol error
// BEHAVIOUR
//  Reset: state=ARB, rr_ptr=0, FIFO empty, err_o=0; hence gnt_o, rvalid_o, cache_req_o=0 and busy_o=0.
//  FSM ARB:
//   - If FIFO not full and any req_i: pick the first requester at or after rr_ptr (cyclic).
//   - Drive cache_req_o/addr/be from the winner combinationally, in the same cycle.
//   - cache_gnt_i=1: gnt_o[win]=1, push win, rr_ptr<=(win+1)%NumPorts, stay in ARB.
//   - cache_gnt_i=0: latch win and go to HOLD.
//  FSM HOLD:
//   - Drive the latched port only; no rearbitration even if higher-priority requests appear.
//   - On cache_gnt_i: gnt_o[latched]=1, push, rr_ptr advances past latched, go to ARB.
//   - If the latched req_i drops before grant (protocol violation): set err_o, drop cache_req_o, go to ARB.
//  Tag FIFO: depth MaxOutstanding, entries $clog2(NumPorts) bits.
//   - FIFO full: cache_req_o=0 in ARB; a pop in the same cycle does not unblock it (registered full flag).
//   - HOLD is entered only when the FIFO is not full, so a HOLD grant always pushes.
//  Response: cache_rvalid_i pops the head; rvalid_o[head]=1 and rdata_o=cache_rdata_i in the same cycle
//   (0-cycle latency); rvalid_o is otherwise all-zero.
//  Simultaneous push and pop in one cycle is supported; occupancy is unchanged.
//  cache_rvalid_i with an empty FIFO: set err_o, no rvalid_o pulse, FIFO unchanged.
//  cache_gnt_i while cache_req_o=0: ignored.
//  Read and write pointers wrap modulo MaxOutstanding; the count saturates by construction.
//  err_o clears only on reset.
//  Reset mid-transaction: all state is cleared at once; in-flight responses are lost (err_o may set if they arrive).
//  Latency: request to cache_req_o 0 cycles in ARB; no extra arbitration bubble between back-to-back grants.
// TESTING
//  1. req_i=3'b111 held, cache_gnt_i=1 each cycle, rvalid 1 cycle later ->
//     grants rotate 0,1,2,0; rvalid_o follows the same order.
//  2. Port1 requests, cache_gnt_i low for 3 cycles, port0 raises req in cycle 2 ->
//     cache_addr_o stays port1's; gnt_o=3'b010 on cycle 4.
//  3. MaxOutstanding=2, two grants with no response -> cache_req_o=0 with req pending.
//     One cache_rvalid_i -> next request is issued the following cycle, not the same cycle.
//  4. FIFO at 1 entry: grant and cache_rvalid_i in the same cycle ->
//     occupancy stays 1; rvalid_o for the old head, correct rdata_o.
//  5. cache_rvalid_i with empty FIFO -> err_o=1 and stays 1; rvalid_o=0.
//  6. rst_i pulsed while in HOLD with 1 outstanding -> next cycle state=ARB, busy_o=0, rr_ptr=0.

Source files
------------

// File: rtl/dcache_rd_port_arbiter_if.sv
// Bus bundles for the dcache read-port arbiter: requester side and cache side.
// The arbiter is the slave of the requester bundle and the master of the cache bundle.

interface dcache_rd_req_if #(
    parameter int NumPorts  = 3,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic [NumPorts-1:0]              req_i;
    logic [NumPorts*AddrWidth-1:0]    addr_i;
    logic [NumPorts*DataWidth/8-1:0]  be_i;
    logic [NumPorts-1:0]              gnt_o;
    logic [NumPorts-1:0]              rvalid_o;
    logic [DataWidth-1:0]             rdata_o;

    modport master (output req_i, addr_i, be_i, input gnt_o, rvalid_o, rdata_o);
    modport slave  (input req_i, addr_i, be_i, output gnt_o, rvalid_o, rdata_o);
endinterface

interface dcache_rd_cache_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                    cache_req_o;
    logic [AddrWidth-1:0]    cache_addr_o;
    logic [DataWidth/8-1:0]  cache_be_o;
    logic                    cache_gnt_i;
    logic                    cache_rvalid_i;
    logic [DataWidth-1:0]    cache_rdata_i;

    modport master (output cache_req_o, cache_addr_o, cache_be_o,
                    input  cache_gnt_i, cache_rvalid_i, cache_rdata_i);
    modport slave  (input  cache_req_o, cache_addr_o, cache_be_o,
                    output cache_gnt_i, cache_rvalid_i, cache_rdata_i);
endinterface

// File: rtl/dcache_rd_port_arbiter.sv
// Round-robin arbiter sharing one write-through dcache read port among several in-order
// requesters; an in-order tag FIFO steers each cache response back to its issuer.

module dcache_rd_port_arbiter #(
    parameter int NumPorts       = 3,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_rd_req_if.slave     req_bus,
    dcache_rd_cache_if.master  cache_bus,
    output logic               busy_o,
    output logic               err_o
);

    localparam int BeWidth  = DataWidth / 8;
    localparam int TagWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [TagWidth-1:0] rr_index(input logic [TagWidth-1:0] base,
                                                     input int off);
        return TagWidth'((int'(base) + off) % NumPorts);
    endfunction

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (int'(ptr) == MaxOutstanding - 1) begin
            return '0;
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

    state_e                 state_q, state_d;
    logic [TagWidth-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TagWidth-1:0]    hold_port_q, hold_port_d;
    logic [TagWidth-1:0]    fifo_q [MaxOutstanding];
    logic [TagWidth-1:0]    fifo_d [MaxOutstanding];
    logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic                   full_q, full_d;
    logic                   err_q, err_d;

    logic                   win_valid_s;
    logic [TagWidth-1:0]    win_s;
    logic [TagWidth-1:0]    sel_s;
    logic                   cache_req_s;
    logic [NumPorts-1:0]    gnt_s;
    logic                   push_s;
    logic                   pop_s;
    logic [TagWidth-1:0]    head_s;
    logic [NumPorts-1:0]    rvalid_s;
    logic [DataWidth-1:0]   rdata_s;

    // Round-robin pick: first requester at or after rr_ptr, cyclically.
    always_comb begin
        win_valid_s = 1'b0;
        win_s       = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!win_valid_s && req_bus.req_i[rr_index(rr_ptr_q, i)]) begin
                win_valid_s = 1'b1;
                win_s       = rr_index(rr_ptr_q, i);
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // FSM next state, grant generation and response routing.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_port_d = hold_port_q;
        err_d       = err_q;
        sel_s       = win_s;
        cache_req_s = 1'b0;
        gnt_s       = '0;
        push_s      = 1'b0;

        case (state_q)
            ARB: begin
                // full_q is registered, so a pop this cycle cannot release the block
                if (!full_q && win_valid_s) begin
                    cache_req_s = 1'b1;
                    if (cache_bus.cache_gnt_i) begin
                        gnt_s[win_s] = 1'b1;
                        push_s       = 1'b1;
                        rr_ptr_d     = rr_index(win_s, 1);
                    end else begin
                        hold_port_d = win_s;
                        state_d     = HOLD;
                    end
                end else begin
                    cache_req_s = 1'b0;
                end
            end
            HOLD: begin
                sel_s = hold_port_q;
                if (req_bus.req_i[hold_port_q]) begin
                    cache_req_s = 1'b1;
                    if (cache_bus.cache_gnt_i) begin
                        gnt_s[hold_port_q] = 1'b1;
                        push_s             = 1'b1;
                        rr_ptr_d           = rr_index(hold_port_q, 1);
                        state_d            = ARB;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase

        pop_s    = cache_bus.cache_rvalid_i && (cnt_q != '0);
        head_s   = fifo_q[rd_ptr_q];
        rvalid_s = '0;
        rdata_s  = '0;
        if (pop_s) begin
            rvalid_s[head_s] = 1'b1;
            rdata_s          = cache_bus.cache_rdata_i;
        end else if (cache_bus.cache_rvalid_i) begin
            err_d = 1'b1;
        end else begin
            rdata_s = '0;
        end
    end

    // Tag FIFO bookkeeping; push and pop may coincide.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = sel_s;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == CntWidth'(MaxOutstanding));
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            hold_port_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_port_q <= hold_port_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            err_q       <= err_d;
            fifo_q      <= fifo_d;
        end
    end

    assign req_bus.gnt_o          = gnt_s;
    assign req_bus.rvalid_o       = rvalid_s;
    assign req_bus.rdata_o        = rdata_s;
    assign cache_bus.cache_req_o  = cache_req_s;
    assign cache_bus.cache_addr_o = cache_req_s ?
                                    req_bus.addr_i[int'(sel_s)*AddrWidth +: AddrWidth] : '0;
    assign cache_bus.cache_be_o   = cache_req_s ?
                                    req_bus.be_i[int'(sel_s)*BeWidth +: BeWidth] : '0;
    assign busy_o                 = (state_q == HOLD) || (cnt_q != '0);
    assign err_o                  = err_q;

endmodule

// File: tb/tb_dcache_rd_port_arbiter.sv
// Directed bench for dcache_rd_port_arbiter: inline checks on grant/request outputs plus a
// scoreboard queue that a negedge monitor drains whenever a response is routed.

module tb_dcache_rd_port_arbiter;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    int checks;
    int errors;

    logic [2:0]  exp_port_q [$];
    logic [31:0] exp_data_q [$];

    dcache_rd_req_if   #(.NumPorts(3), .AddrWidth(32), .DataWidth(32)) req_bus ();
    dcache_rd_cache_if #(.AddrWidth(32), .DataWidth(32))               cache_bus ();

    dcache_rd_port_arbiter #(
        .NumPorts(3), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_bus  (req_bus),
        .cache_bus(cache_bus),
        .busy_o   (busy),
        .err_o    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; exp_port >= 0 queues the response the monitor must see.
    task automatic cyc(input logic [2:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd, input int exp_port);
        logic [2:0] oh;
        @(posedge clk);
        #1;
        req_bus.req_i            = req;
        cache_bus.cache_gnt_i    = gnt;
        cache_bus.cache_rvalid_i = rv;
        cache_bus.cache_rdata_i  = rd;
        if (rv && exp_port >= 0) begin
            oh = 3'b001 << exp_port;
            exp_port_q.push_back(oh);
            exp_data_q.push_back(rd);
        end
        @(negedge clk);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && req_bus.rvalid_o != 3'b000) begin
            if (exp_port_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got %b expected none", req_bus.rvalid_o);
            end else begin
                chk("rvalid_port", {29'd0, req_bus.rvalid_o}, {29'd0, exp_port_q.pop_front()});
                chk("rdata", req_bus.rdata_o, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req_bus.req_i            = 3'b000;
        req_bus.addr_i           = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        req_bus.be_i             = {4'hF, 4'h3, 4'h1};
        cache_bus.cache_gnt_i    = 1'b0;
        cache_bus.cache_rvalid_i = 1'b0;
        cache_bus.cache_rdata_i  = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {29'd0, req_bus.gnt_o}, 32'd0);
        chk("rst_cache_req", {31'd0, cache_bus.cache_req_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: rotation 0,1,2,0 with responses one cycle behind
        cyc(3'b111, 1'b1, 1'b0, 32'h0, -1);
        chk("t1_gnt0", {29'd0, req_bus.gnt_o}, 32'd1);
        chk("t1_addr0", cache_bus.cache_addr_o, 32'hAAAA_0000);
        chk("t1_be0", {28'd0, cache_bus.cache_be_o}, 32'h1);
        cyc(3'b111, 1'b1, 1'b1, 32'h101, 0);
        chk("t1_gnt1", {29'd0, req_bus.gnt_o}, 32'd2);
        chk("t1_addr1", cache_bus.cache_addr_o, 32'hBBBB_0001);
        cyc(3'b111, 1'b1, 1'b1, 32'h102, 1);
        chk("t1_gnt2", {29'd0, req_bus.gnt_o}, 32'd4);
        cyc(3'b111, 1'b1, 1'b1, 32'h103, 2);
        chk("t1_gnt3", {29'd0, req_bus.gnt_o}, 32'd1);
        cyc(3'b000, 1'b0, 1'b1, 32'h104, 0);
        chk("t1_idle_req", {31'd0, cache_bus.cache_req_o}, 32'd0);

        // 2: port1 held without grant, port0 arrives later, no rearbitration
        cyc(3'b010, 1'b0, 1'b0, 32'h0, -1);
        chk("t2_req", {31'd0, cache_bus.cache_req_o}, 32'd1);
        chk("t2_addr_a", cache_bus.cache_addr_o, 32'hBBBB_0001);
        cyc(3'b011, 1'b0, 1'b0, 32'h0, -1);
        chk("t2_addr_b", cache_bus.cache_addr_o, 32'hBBBB_0001);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        cyc(3'b011, 1'b0, 1'b0, 32'h0, -1);
        chk("t2_addr_c", cache_bus.cache_addr_o, 32'hBBBB_0001);
        chk("t2_nogrant", {29'd0, req_bus.gnt_o}, 32'd0);
        cyc(3'b011, 1'b1, 1'b0, 32'h0, -1);
        chk("t2_gnt", {29'd0, req_bus.gnt_o}, 32'd2);
        cyc(3'b000, 1'b0, 1'b1, 32'h202, 1);

        // 3: two outstanding blocks the port; a pop unblocks only the next cycle
        cyc(3'b100, 1'b1, 1'b0, 32'h0, -1);
        chk("t3_busy_idle", {31'd0, busy}, 32'd0);
        chk("t3_gnt_a", {29'd0, req_bus.gnt_o}, 32'd4);
        cyc(3'b001, 1'b1, 1'b0, 32'h0, -1);
        chk("t3_gnt_b", {29'd0, req_bus.gnt_o}, 32'd1);
        cyc(3'b010, 1'b1, 1'b0, 32'h0, -1);
        chk("t3_full_req", {31'd0, cache_bus.cache_req_o}, 32'd0);
        chk("t3_full_gnt", {29'd0, req_bus.gnt_o}, 32'd0);
        cyc(3'b010, 1'b1, 1'b1, 32'h303, 2);
        chk("t3_pop_req", {31'd0, cache_bus.cache_req_o}, 32'd0);
        chk("t3_pop_gnt", {29'd0, req_bus.gnt_o}, 32'd0);
        cyc(3'b010, 1'b1, 1'b0, 32'h0, -1);
        chk("t3_after_req", {31'd0, cache_bus.cache_req_o}, 32'd1);
        chk("t3_after_gnt", {29'd0, req_bus.gnt_o}, 32'd2);
        cyc(3'b000, 1'b0, 1'b1, 32'h304, 0);

        // 4: one entry, grant and response together
        cyc(3'b001, 1'b1, 1'b1, 32'h405, 1);
        chk("t4_gnt", {29'd0, req_bus.gnt_o}, 32'd1);
        cyc(3'b000, 1'b0, 1'b1, 32'h406, 0);
        chk("t4_busy_occ1", {31'd0, busy}, 32'd1);
        cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
        chk("t4_busy_empty", {31'd0, busy}, 32'd0);
        chk("t4_err_clean", {31'd0, err}, 32'd0);

        // 5: response with empty FIFO
        cyc(3'b000, 1'b0, 1'b1, 32'h777, -1);
        chk("t5_rvalid", {29'd0, req_bus.rvalid_o}, 32'd0);
        cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
        chk("t5_err", {31'd0, err}, 32'd1);
        cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
        cyc(3'b000, 1'b0, 1'b0, 32'h0, -1);
        chk("t5_err_sticky", {31'd0, err}, 32'd1);

        // 6: reset while in HOLD with one outstanding
        cyc(3'b010, 1'b1, 1'b0, 32'h0, -1);
        chk("t6_gnt", {29'd0, req_bus.gnt_o}, 32'd2);
        cyc(3'b100, 1'b0, 1'b0, 32'h0, -1);
        chk("t6_hold_addr", cache_bus.cache_addr_o, 32'hCCCC_0002);
        chk("t6_hold_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_bus.req_i = 3'b000;
        cache_bus.cache_gnt_i = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_post_busy", {31'd0, busy}, 32'd0);
        chk("t6_post_err", {31'd0, err}, 32'd0);
        chk("t6_post_req", {31'd0, cache_bus.cache_req_o}, 32'd0);
        cyc(3'b111, 1'b1, 1'b0, 32'h0, -1);
        chk("t6_rr_zero", {29'd0, req_bus.gnt_o}, 32'd1);

        chk("sb_drained", exp_port_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
